// File: rtl/aes_cipher_serializer_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared constants, FSM encoding and helpers for the AES ciphertext serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    function automatic int beats(input int out_w);
        return AES_BLK_W / out_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_cipher_serializer_if.sv
// ============================================================================
// Module   : aes_cipher_serializer_if
// Brief    : Block-capture and beat-stream signals between the AES core, serializer and sink.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface aes_cipher_serializer_if #(
    parameter int OUT_W = 8
);

    logic                           blk_valid;
    logic [aes_pkg::AES_BLK_W-1:0]  blk_data;
    logic                           blk_ready;
    logic                           out_valid;
    logic [OUT_W-1:0]               out_data;
    logic                           out_ready;
    logic                           out_last;
    logic                           overflow;
    logic                           clear_ovf;

    modport master (
        output blk_valid, blk_data, out_ready, clear_ovf,
        input  blk_ready, out_valid, out_data, out_last, overflow
    );

    modport slave (
        input  blk_valid, blk_data, out_ready, clear_ovf,
        output blk_ready, out_valid, out_data, out_last, overflow
    );

endinterface

`default_nettype wire

// File: rtl/aes_cipher_serializer_fifo2.sv
// ============================================================================
// Module   : aes_blk_fifo2
// Brief    : Two-entry 128-bit block buffer; head is always visible on dout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_blk_fifo2
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [AES_BLK_W-1:0]  din,
    input  logic                  pop,
    output logic [AES_BLK_W-1:0]  dout,
    output logic [1:0]            count,
    output logic                  full
);

    logic [AES_BLK_W-1:0] mem [2];
    logic                 head;
    logic                 tail;
    logic [1:0]           cnt;
    logic                 do_push;
    logic                 do_pop;

    // Guarded here as well so the buffer can never over- or under-run.
    assign do_push = push && (cnt != 2'd2);
    assign do_pop  = pop  && (cnt != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[tail] <= din;
                tail      <= ~tail;
            end
            if (do_pop) begin
                head <= ~head;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[head];
    assign count = cnt;
    assign full  = (cnt == 2'd2);

endmodule

`default_nettype wire

// File: rtl/aes_cipher_serializer.sv
// ============================================================================
// Module   : aes_cipher_serializer
// Brief    : Buffers AES ciphertext blocks and streams them MSB-first as OUT_W-bit beats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_cipher_serializer
    import aes_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    aes_cipher_serializer_if.slave   bus
);

    localparam int             BEATS     = beats(OUT_W);
    localparam int             CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     beat;
    logic [CNT_W-1:0]     beat_nxt;
    logic [AES_BLK_W-1:0] head_blk;
    logic [AES_BLK_W-1:0] shifted;
    logic [1:0]           count;
    logic                 full;
    logic                 push;
    logic                 drop;
    logic                 xfer;
    logic                 at_last;
    logic                 pop;
    logic                 ovf_q;

    // The core cannot be stalled, so a strobe into a full buffer is lost.
    assign push    = bus.blk_valid && !full;
    assign drop    = bus.blk_valid &&  full;
    assign xfer    = (state == S_SHIFT) && bus.out_ready;
    assign at_last = (beat == LAST_BEAT);
    assign pop     = xfer && at_last;

    aes_blk_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.blk_data),
        .pop   (pop),
        .dout  (head_blk),
        .count (count),
        .full  (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        case (state)
            S_EMPTY: begin
                beat_nxt = '0;
                if (push) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (xfer) begin
                    beat_nxt = at_last ? '0 : beat + CNT_W'(1);
                    // Stay in S_SHIFT when another block is queued or arriving now.
                    if (at_last && (count == 2'd1) && !push) begin
                        state_nxt = S_EMPTY;
                    end
                end
            end
            default: begin
                state_nxt = S_EMPTY;
                beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (bus.clear_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign shifted       = head_blk << (int'(beat) * OUT_W);
    assign bus.out_valid = (state == S_SHIFT);
    assign bus.out_data  = bus.out_valid ? shifted[AES_BLK_W-1 -: OUT_W] : '0;
    assign bus.out_last  = bus.out_valid && at_last;
    assign bus.blk_ready = !rst && !full;
    assign bus.overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_cipher_serializer.sv
// ============================================================================
// Module   : tb_aes_cipher_serializer
// Brief    : Scoreboard bench for the AES ciphertext serializer at OUT_W = 8 and 32.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_cipher_serializer;

    typedef struct packed {
        logic [63:0] d;
        logic        last;
    } beat_t;

    localparam logic [127:0] BLK_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BLK_C = 128'hdeadbeefcafef00d0123456789abcdef;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks   = 0;
    int    failures = 0;
    beat_t q8[$];
    beat_t q32[$];

    aes_cipher_serializer_if #(.OUT_W(8))  b8 ();
    aes_cipher_serializer_if #(.OUT_W(32)) b32 ();

    aes_cipher_serializer #(.OUT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    aes_cipher_serializer #(.OUT_W(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp8(input logic [127:0] blk);
        for (int i = 0; i < 16; i++) begin
            beat_t b;
            b.d    = 64'(blk[127 - 8*i -: 8]);
            b.last = (i == 15);
            q8.push_back(b);
        end
    endtask

    task automatic push_exp32(input logic [127:0] blk);
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.d    = 64'(blk[127 - 32*i -: 32]);
            b.last = (i == 3);
            q32.push_back(b);
        end
    endtask

    task automatic strobe8(input logic [127:0] blk, input bit accept);
        b8.blk_data  = blk;
        b8.blk_valid = 1'b1;
        if (accept) push_exp8(blk);
        @(posedge clk); #1;
        b8.blk_valid = 1'b0;
    endtask

    task automatic drain8(input string tag, input int max_cycles);
        int n = 0;
        while ((q8.size() != 0 || b8.out_valid) && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 128'(n < max_cycles), 128'd1);
    endtask

    // Scoreboard and stall-stability monitors, sampled mid-cycle.
    logic       stall8 = 1'b0;
    logic [7:0] hold_d8;
    logic       hold_l8;

    always @(negedge clk) begin
        if (rst) begin
            stall8 = 1'b0;
        end else begin
            if (stall8) begin
                check("stall_hold_data8", 128'(b8.out_data), 128'(hold_d8));
                check("stall_hold_last8", 128'(b8.out_last), 128'(hold_l8));
            end
            if (b8.out_valid && b8.out_ready) begin
                if (q8.size() == 0) begin
                    check("unexpected_beat8", 128'(b8.out_data), 128'hx);
                end else begin
                    beat_t e;
                    e = q8.pop_front();
                    check("beat_data8", 128'(b8.out_data), 128'(e.d[7:0]));
                    check("beat_last8", 128'(b8.out_last), 128'(e.last));
                end
            end
            stall8  = b8.out_valid && !b8.out_ready;
            hold_d8 = b8.out_data;
            hold_l8 = b8.out_last;
        end
    end

    always @(negedge clk) begin
        if (!rst && b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) begin
                check("unexpected_beat32", 128'(b32.out_data), 128'hx);
            end else begin
                beat_t e;
                e = q32.pop_front();
                check("beat_data32", 128'(b32.out_data), 128'(e.d[31:0]));
                check("beat_last32", 128'(b32.out_last), 128'(e.last));
            end
        end
    end

    initial begin
        b8.blk_valid  = 1'b0;
        b8.blk_data   = '0;
        b8.out_ready  = 1'b1;
        b8.clear_ovf  = 1'b0;
        b32.blk_valid = 1'b0;
        b32.blk_data  = '0;
        b32.out_ready = 1'b1;
        b32.clear_ovf = 1'b0;

        // Outputs during reset
        #12;
        check("rst_out_valid", 128'(b8.out_valid), 128'd0);
        check("rst_out_data",  128'(b8.out_data),  128'd0);
        check("rst_out_last",  128'(b8.out_last),  128'd0);
        check("rst_overflow",  128'(b8.overflow),  128'd0);
        check("rst_blk_ready", 128'(b8.blk_ready), 128'd0);
        #11;
        rst = 1'b0;
        #1;
        check("post_rst_blk_ready", 128'(b8.blk_ready), 128'd1);
        @(posedge clk); #1;

        // Single block, sink always ready
        strobe8(BLK_A, 1'b1);
        check("lat_valid", 128'(b8.out_valid), 128'd1);
        check("lat_data",  128'(b8.out_data),  128'h69);
        check("lat_last",  128'(b8.out_last),  128'd0);
        repeat (15) @(posedge clk);
        #1;
        check("t1_last_beat_data", 128'(b8.out_data), 128'h5a);
        check("t1_last_beat_flag", 128'(b8.out_last), 128'd1);
        @(posedge clk); #1;
        check("t1_idle_valid", 128'(b8.out_valid), 128'd0);
        check("t1_queue_empty", 128'(q8.size()), 128'd0);

        // Same block under a 1,0,0 ready pattern
        strobe8(BLK_A, 1'b1);
        for (int i = 0; i < 120 && q8.size() != 0; i++) begin
            b8.out_ready = (i % 3 == 0);
            @(posedge clk); #1;
        end
        b8.out_ready = 1'b1;
        check("t2_queue_empty", 128'(q8.size()), 128'd0);
        drain8("t2_drain_timeout", 40);

        // Back-to-back blocks, no bubble between them
        strobe8(BLK_A, 1'b1);
        strobe8(BLK_B, 1'b1);
        check("t3_full_ready", 128'(b8.blk_ready), 128'd0);
        repeat (14) @(posedge clk);
        #1;
        check("t3_still_full", 128'(b8.blk_ready), 128'd0);
        @(posedge clk); #1;
        check("t3_ready_after_pop", 128'(b8.blk_ready), 128'd1);
        check("t3_b_first_byte", 128'(b8.out_data), 128'h00);
        repeat (16) @(posedge clk);
        #1;
        check("t3_idle_valid", 128'(b8.out_valid), 128'd0);
        check("t3_queue_empty", 128'(q8.size()), 128'd0);

        // Overflow: third strobe dropped, set wins over a same-cycle clear
        b8.out_ready = 1'b0;
        strobe8(BLK_A, 1'b1);
        strobe8(BLK_B, 1'b1);
        b8.clear_ovf = 1'b1;
        strobe8(BLK_C, 1'b0);
        b8.clear_ovf = 1'b0;
        check("t4_overflow_set", 128'(b8.overflow), 128'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t4_overflow_sticky", 128'(b8.overflow), 128'd1);
        check("t4_head_held", 128'(b8.out_data), 128'h69);
        b8.clear_ovf = 1'b1;
        @(posedge clk); #1;
        b8.clear_ovf = 1'b0;
        check("t4_overflow_clear", 128'(b8.overflow), 128'd0);
        b8.out_ready = 1'b1;
        drain8("t4_drain_timeout", 60);
        check("t4_queue_empty", 128'(q8.size()), 128'd0);

        // Asynchronous reset after beat 5
        strobe8(BLK_A, 1'b1);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        q8.delete();
        check("t5_rst_valid", 128'(b8.out_valid), 128'd0);
        check("t5_rst_data",  128'(b8.out_data),  128'd0);
        check("t5_rst_last",  128'(b8.out_last),  128'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t5_ready_after_rst", 128'(b8.blk_ready), 128'd1);
        check("t5_valid_after_rst", 128'(b8.out_valid), 128'd0);
        @(posedge clk); #1;
        strobe8(BLK_B, 1'b1);
        check("t5_first_byte", 128'(b8.out_data), 128'h00);
        drain8("t5_drain_timeout", 40);

        // 32-bit beats
        b32.blk_data  = BLK_A;
        b32.blk_valid = 1'b1;
        push_exp32(BLK_A);
        @(posedge clk); #1;
        b32.blk_valid = 1'b0;
        check("w32_first", 128'(b32.out_data), 128'h69c4e0d8);
        repeat (3) @(posedge clk);
        #1;
        check("w32_last_data", 128'(b32.out_data), 128'h70b4c55a);
        check("w32_last_flag", 128'(b32.out_last), 128'd1);
        @(posedge clk); #1;
        check("w32_idle", 128'(b32.out_valid), 128'd0);
        check("w32_queue_empty", 128'(q32.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
